calc_envelope_shift_multi: RTL and testbench

Parametrised envelope-rate shift generator for the OPL2/OPL3 envelope path. It sits between the operator register file and the envelope generator. For each operator slot it computes the key-scaled rate and the per-sample attenuation shift from a shared global envelope timer. It generalises the single-configuration OPL2 generator in three ways: operator count and timer width are parameters, and a synchronous timer clear (test-register driven) is added.

---
 rtl/calc_envelope_shift_multi.sv | 230 +++++++++++++++++++++++
 tb/tb_calc_envelope_shift_multi.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_envelope_shift_multi.sv
// calc_envelope_shift_multi
// Per-slot envelope rate / attenuation shift generator for the OPL2/OPL3 EG.
//
// Computes the key-scaled rate of each operator slot and the per-sample
// attenuation shift derived from a shared global envelope timer.
// Latency: 2 clocks from p0 inputs to p2 outputs; one slot per clock.
//
// Optional feature macro: OPL_EG_TIMER_HOLD_EN
//   When defined, adds input eg_timer_hold that freezes the sample-end
//   bookkeeping (timer, eg_state, eg_add, timer_lo) while high.
//
// Ports:
//   clk                system clock
//   reset              asynchronous active-high reset
//   sample_clk_en      slot-valid strobe accompanying op_num
//   op_num             current operator slot (p0)
//   ksr                key-scale-rate enable
//   nts                keyboard split select
//   fnum               frequency number (10 bits)
//   block              octave (3 bits)
//   requested_rate_p0  attack/decay/release rate of the slot
//   eg_timer_clr       synchronous clear of the global envelope state
//   eg_timer_hold      (OPL_EG_TIMER_HOLD_EN only) freeze global state
//   rate_hi_p2         effective rate high nibble, saturated to 15
//   env_shift_p2       attenuation shift for the slot

module calc_envelope_shift_multi #(
    parameter int NUM_OPS         = 18,
    parameter int OP_NUM_WIDTH    = $clog2(NUM_OPS),
    parameter int EG_TIMER_WIDTH  = 13,
    parameter int ENV_SHIFT_WIDTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       sample_clk_en,
    input  logic [OP_NUM_WIDTH-1:0]    op_num,
    input  logic                       ksr,
    input  logic                       nts,
    input  logic [9:0]                 fnum,
    input  logic [2:0]                 block,
    input  logic [3:0]                 requested_rate_p0,
    input  logic                       eg_timer_clr,
`ifdef OPL_EG_TIMER_HOLD_EN
    input  logic                       eg_timer_hold,
`endif
    output logic [3:0]                 rate_hi_p2,
    output logic [ENV_SHIFT_WIDTH-1:0] env_shift_p2
);

    localparam int EG_ADD_WIDTH = $clog2(EG_TIMER_WIDTH + 1);
    localparam logic [OP_NUM_WIDTH-1:0] LAST_OP = OP_NUM_WIDTH'(NUM_OPS - 1);

    // ------------------------------------------------------------------
    // Trailing-zero count of the timer plus one; zero for a zero timer.
    // Scanning from the top leaves the lowest set bit as the result.
    // ------------------------------------------------------------------
    function automatic logic [EG_ADD_WIDTH-1:0] tz_plus1(
        input logic [EG_TIMER_WIDTH-1:0] t
    );
        logic [EG_ADD_WIDTH-1:0] r;
        r = '0;
        for (int i = EG_TIMER_WIDTH - 1; i >= 0; i--) begin
            if (t[i]) begin
                r = EG_ADD_WIDTH'(i + 1);
            end
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Stage p0: key scaling and raw rate
    // ------------------------------------------------------------------
    logic [3:0] ksv;
    logic [3:0] ks;
    logic [6:0] rate_p0;
    logic       rate_nz_p0;
    logic       last_slot_p0;

    always_comb begin
        ksv          = {block, nts ? fnum[8] : fnum[9]};
        ks           = ksr ? ksv : {2'b00, ksv[3:2]};
        rate_p0      = 7'(ks) + {1'b0, requested_rate_p0, 2'b00};
        rate_nz_p0   = |requested_rate_p0;
        last_slot_p0 = sample_clk_en && (op_num == LAST_OP);
    end

    // Only fnum[9:8] feed key scaling.
    logic unused_fnum;
    assign unused_fnum = ^fnum[7:0];

    // ------------------------------------------------------------------
    // Stage p1 registers
    // ------------------------------------------------------------------
    logic [6:0] rate_p1;
    logic       rate_nz_p1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rate_p1    <= '0;
            rate_nz_p1 <= 1'b0;
        end else begin
            rate_p1    <= rate_p0;
            rate_nz_p1 <= rate_nz_p0;
        end
    end

    // ------------------------------------------------------------------
    // Sample-end detection, delayed so the final slot of a sample still
    // sees the state that was in force for the rest of that sample.
    // ------------------------------------------------------------------
    logic [2:0] end_dly;
    logic       sample_end;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            end_dly <= '0;
        end else begin
            end_dly <= {end_dly[1:0], last_slot_p0};
        end
    end

    assign sample_end = end_dly[2];

    // ------------------------------------------------------------------
    // Global envelope state
    // ------------------------------------------------------------------
    logic [EG_TIMER_WIDTH-1:0] eg_timer;
    logic                      eg_state;
    logic [EG_ADD_WIDTH-1:0]   eg_add;
    logic [1:0]                timer_lo;
    logic                      update_hold;

`ifdef OPL_EG_TIMER_HOLD_EN
    assign update_hold = eg_timer_hold;
`else
    assign update_hold = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            eg_timer <= '0;
            eg_state <= 1'b0;
            eg_add   <= '0;
            timer_lo <= '0;
        end else if (eg_timer_clr) begin
            eg_timer <= '0;
            eg_state <= 1'b0;
            eg_add   <= '0;
            timer_lo <= '0;
        end else if (sample_end && !update_hold) begin
            // The timer advances on every second sample only.
            if (eg_state) begin
                eg_add   <= tz_plus1(eg_timer);
                timer_lo <= eg_timer[1:0];
                eg_timer <= eg_timer + EG_TIMER_WIDTH'(1);
            end
            eg_state <= ~eg_state;
        end
    end

    // ------------------------------------------------------------------
    // Stage p1 -> p2: shift computation
    // ------------------------------------------------------------------
    logic [3:0] rate_hi;
    logic [1:0] rate_lo;
    logic [5:0] eg_shift;
    logic       step;
    logic [2:0] pre;
    logic [1:0] shift_lo;
    logic [1:0] shift_hi;
    logic [1:0] shift_p1;

    always_comb begin
        rate_hi  = rate_p1[6] ? 4'd15 : rate_p1[5:2];
        rate_lo  = rate_p1[1:0];
        eg_shift = 6'(rate_hi) + 6'(eg_add);

        // Slow rates: a single shift step on selected timer positions.
        shift_lo = 2'd0;
        if (eg_state) begin
            case (eg_shift)
                6'd12:   shift_lo = 2'd1;
                6'd13:   shift_lo = {1'b0, rate_lo[1]};
                6'd14:   shift_lo = {1'b0, rate_lo[0]};
                default: shift_lo = 2'd0;
            endcase
        end

        // Fast rates: fractional step pattern indexed by timer_lo.
        step = 1'b0;
        case (rate_lo)
            2'd0:    step = 1'b0;
            2'd1:    step = (timer_lo == 2'd0);
            2'd2:    step = ~timer_lo[0];
            default: step = (timer_lo != 2'd3);
        endcase

        pre = {1'b0, rate_hi[1:0]} + {2'b00, step};

        shift_hi = pre[1:0];
        if (pre[2]) begin
            shift_hi = 2'd3;
        end else if (pre == 3'd0) begin
            shift_hi = {1'b0, eg_state};
        end

        shift_p1 = 2'd0;
        if (!rate_nz_p1) begin
            shift_p1 = 2'd0;
        end else if (rate_hi < 4'd12) begin
            shift_p1 = shift_lo;
        end else begin
            shift_p1 = shift_hi;
        end
    end

    // ------------------------------------------------------------------
    // Stage p2 registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rate_hi_p2   <= '0;
            env_shift_p2 <= '0;
        end else begin
            rate_hi_p2   <= rate_hi;
            env_shift_p2 <= ENV_SHIFT_WIDTH'(shift_p1);
        end
    end

endmodule

// File: tb/tb_calc_envelope_shift_multi.sv
// tb_calc_envelope_shift_multi
// Scoreboard bench for calc_envelope_shift_multi (default parameters).

module tb_calc_envelope_shift_multi;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       sample_clk_en = 1'b0;
    logic [4:0] op_num = '0;
    logic       ksr = 1'b0;
    logic       nts = 1'b0;
    logic [9:0] fnum = '0;
    logic [2:0] block = '0;
    logic [3:0] requested_rate_p0 = '0;
    logic       eg_timer_clr = 1'b0;
    logic       hold_m = 1'b0;
    logic [3:0] rate_hi_p2;
    logic [1:0] env_shift_p2;

    calc_envelope_shift_multi dut (
        .clk               (clk),
        .reset             (reset),
        .sample_clk_en     (sample_clk_en),
        .op_num            (op_num),
        .ksr               (ksr),
        .nts               (nts),
        .fnum              (fnum),
        .block             (block),
        .requested_rate_p0 (requested_rate_p0),
        .eg_timer_clr      (eg_timer_clr),
`ifdef OPL_EG_TIMER_HOLD_EN
        .eg_timer_hold     (hold_m),
`endif
        .rate_hi_p2        (rate_hi_p2),
        .env_shift_p2      (env_shift_p2)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] rh;
        logic [1:0] env;
        logic [7:0] tag;
    } exp_t;

    typedef struct packed {
        logic       k;
        logic       n;
        logic [9:0] f;
        logic [2:0] b;
        logic [3:0] rr;
    } pcfg_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model of the global envelope state
    logic [12:0] m_timer = '0;
    logic        m_state = 1'b0;
    logic [3:0]  m_add = '0;
    logic [1:0]  m_tlo = '0;

    // Output-valid tracking, two clocks behind sample_clk_en
    logic v1, v2;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else begin
            v1 <= sample_clk_en;
            v2 <= v1;
        end
    end

    // Monitor
    always @(negedge clk) begin
        exp_t e;
        if (!reset && v2) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL underflow: output present, nothing expected");
            end else begin
                e = q.pop_front();
                if (rate_hi_p2 !== e.rh || env_shift_p2 !== e.env) begin
                    errors++;
                    $display("FAIL slot tag=%0d got rate_hi=%0d env=%0d want rate_hi=%0d env=%0d (t=%0t)",
                             e.tag, rate_hi_p2, env_shift_p2, e.rh, e.env, $time);
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

    function automatic int tz(input logic [12:0] t);
        int n;
        n = 0;
        while (n < 12 && t[n] == 1'b0) n++;
        return n;
    endfunction

    // Expected {rate_hi, env_shift} derived from the current model state
    function automatic logic [5:0] ref_out(input logic k, input logic n,
                                           input logic [9:0] f,
                                           input logic [2:0] b,
                                           input logic [3:0] rr);
        int ksv, ks, rate, rh, rl, sh, stp, pre, env;
        ksv  = int'(b) * 2 + int'(n ? f[8] : f[9]);
        ks   = k ? ksv : ksv / 4;
        rate = ks + int'(rr) * 4;
        rh   = rate / 4;
        if (rh > 15) rh = 15;
        rl   = rate % 4;
        env  = 0;
        stp  = 0;
        if (rr == 0) begin
            env = 0;
        end else if (rh < 12) begin
            sh = rh + int'(m_add);
            if (m_state) begin
                if (sh == 12) env = 1;
                else if (sh == 13) env = rl / 2;
                else if (sh == 14) env = rl % 2;
            end
        end else begin
            if (rl == 1) stp = (m_tlo == 2'd0) ? 1 : 0;
            if (rl == 2) stp = (m_tlo == 2'd0 || m_tlo == 2'd2) ? 1 : 0;
            if (rl == 3) stp = (m_tlo != 2'd3) ? 1 : 0;
            pre = rh % 4 + stp;
            if (pre >= 4) env = 3;
            else if (pre == 0) env = int'(m_state);
            else env = pre;
        end
        return {4'(rh), 2'(env)};
    endfunction

    function automatic pcfg_t probe_cfg(input int i);
        case (i)
            0:  return {1'b0, 1'b0, 10'h000, 3'd0, 4'd12};
            1:  return {1'b1, 1'b0, 10'h200, 3'd0, 4'd12};
            2:  return {1'b1, 1'b0, 10'h000, 3'd1, 4'd12};
            3:  return {1'b1, 1'b0, 10'h200, 3'd1, 4'd12};
            4:  return {1'b1, 1'b1, 10'h100, 3'd1, 4'd11};
            5:  return {1'b0, 1'b0, 10'h000, 3'd0, 4'd11};
            6:  return {1'b1, 1'b0, 10'h200, 3'd1, 4'd8};
            7:  return {1'b1, 1'b0, 10'h200, 3'd1, 4'd5};
            8:  return {1'b1, 1'b0, 10'h200, 3'd1, 4'd2};
            9:  return {1'b0, 1'b0, 10'h000, 3'd0, 4'd1};
            10: return {1'b1, 1'b0, 10'h200, 3'd7, 4'd0};
            11: return {1'b1, 1'b0, 10'h200, 3'd7, 4'd15};
            12: return {1'b1, 1'b0, 10'h000, 3'd1, 4'd13};
            default: return {1'b0, 1'b0, 10'h200, 3'd7, 4'd5};
        endcase
    endfunction

    task automatic drive(input int op, input logic k, input logic n,
                         input logic [9:0] f, input logic [2:0] b,
                         input logic [3:0] rr, input logic [5:0] ex,
                         input int tag);
        exp_t e;
        @(posedge clk); #1;
        sample_clk_en     = 1'b1;
        op_num            = 5'(op);
        ksr               = k;
        nts               = n;
        fnum              = f;
        block             = b;
        requested_rate_p0 = rr;
        e.rh  = ex[5:2];
        e.env = ex[1:0];
        e.tag = 8'(tag);
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            sample_clk_en = 1'b0;
        end
    endtask

    task automatic m_end(input logic clr);
        if (clr) begin
            m_timer = '0;
            m_state = 1'b0;
            m_add   = '0;
            m_tlo   = '0;
        end else if (!hold_m) begin
            if (m_state) begin
                m_add   = (m_timer == 0) ? 4'd0 : 4'(tz(m_timer) + 1);
                m_tlo   = m_timer[1:0];
                m_timer = m_timer + 13'd1;
            end
            m_state = ~m_state;
        end
    endtask

    // Final slot of a sample; optional clear lands on the update clock
    task automatic end_sample(input logic clr);
        drive(17, 1'b1, 1'b0, 10'h200, 3'd1, 4'd1,
              ref_out(1'b1, 1'b0, 10'h200, 3'd1, 4'd1), 99);
        @(posedge clk); #1;
        sample_clk_en = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        eg_timer_clr = clr;
        @(posedge clk); #1;
        eg_timer_clr = 1'b0;
        m_end(clr);
        idle(1);
    endtask

    task automatic probe_sample(input logic clr);
        pcfg_t c;
        for (int i = 0; i < 14; i++) begin
            c = probe_cfg(i);
            drive(i, c.k, c.n, c.f, c.b, c.rr,
                  ref_out(c.k, c.n, c.f, c.b, c.rr), i);
        end
        end_sample(clr);
    endtask

    // Back-to-back final slots with rate 0 (state-independent output)
    task automatic ff_to(input logic [12:0] t, input logic s);
        while (!(m_timer == t && m_state == s)) begin
            drive(17, 1'b0, 1'b0, 10'h000, 3'd0, 4'd0, 6'd0, 200);
            m_end(1'b0);
        end
        idle(4);
    endtask

    task automatic m_reset();
        m_timer = '0;
        m_state = 1'b0;
        m_add   = '0;
        m_tlo   = '0;
    endtask

    initial begin
        #2 reset = 1'b1;
        #3;
        checks++;
        if (rate_hi_p2 !== 4'd0) begin
            errors++;
            $display("FAIL reset_rate_hi got=%0d want=0", rate_hi_p2);
        end
        checks++;
        if (env_shift_p2 !== 2'd0) begin
            errors++;
            $display("FAIL reset_env got=%0d want=0", env_shift_p2);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Directed vectors with hand-computed results
        drive(0, 1'b1, 1'b0, 10'h200, 3'd7, 4'd0, {4'd3, 2'd0}, 150);
        drive(1, 1'b1, 1'b0, 10'h200, 3'd7, 4'd15, {4'd15, 2'd3}, 151);
        drive(2, 1'b0, 1'b0, 10'h200, 3'd7, 4'd5, {4'd5, 2'd0}, 152);
        drive(3, 1'b1, 1'b1, 10'h100, 3'd0, 4'd12, {4'd12, 2'd1}, 153);
        idle(4);

        // Timer progression from power-on: eg_add 0,1,2,1,3,1,2,1,4
        for (int s = 0; s < 20; s++) probe_sample(1'b0);

        // Reset in the middle of a stream
        drive(0, 1'b1, 1'b0, 10'h200, 3'd7, 4'd15, {4'd15, 2'd3}, 160);
        drive(1, 1'b1, 1'b0, 10'h200, 3'd7, 4'd15, {4'd15, 2'd3}, 161);
        drive(2, 1'b1, 1'b0, 10'h200, 3'd7, 4'd15, {4'd15, 2'd3}, 162);
        @(negedge clk); #2;
        reset = 1'b1;
        sample_clk_en = 1'b0;
        #1;
        checks++;
        if (rate_hi_p2 !== 4'd0) begin
            errors++;
            $display("FAIL midreset_rate_hi got=%0d want=0", rate_hi_p2);
        end
        checks++;
        if (env_shift_p2 !== 2'd0) begin
            errors++;
            $display("FAIL midreset_env got=%0d want=0", env_shift_p2);
        end
        q.delete();
        m_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        probe_sample(1'b0);
        probe_sample(1'b0);
        probe_sample(1'b0);

        // Low-rate hit when timer 0x400 is consumed (eg_add = 11)
        ff_to(13'h400, 1'b1);
        for (int s = 0; s < 4; s++) probe_sample(1'b0);

        // Timer reaches all-ones and wraps
        ff_to(13'h1FFF, 1'b1);
        for (int s = 0; s < 5; s++) probe_sample(1'b0);

        // Clear coincident with a sample-end
        ff_to(13'h006, 1'b0);
        probe_sample(1'b1);
        for (int s = 0; s < 3; s++) probe_sample(1'b0);

`ifdef OPL_EG_TIMER_HOLD_EN
        ff_to(13'h00C, 1'b1);
        probe_sample(1'b0);
        hold_m = 1'b1;
        for (int s = 0; s < 5; s++) probe_sample(1'b0);
        hold_m = 1'b0;
        for (int s = 0; s < 3; s++) probe_sample(1'b0);
`endif

        idle(4);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain leftover=%0d want=0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
